// File: rtl/accelerator_convolutional_fnn_vector_receiver.sv
// FNN vector-load responder: requests SIZE_IN elements one at a time, buffers them,
// then replays the buffer on DATA_OUT with a per-element strobe and a READY pulse.
module accelerator_convolutional_fnn_vector_receiver #(
    parameter int DATA_SIZE = 64,
    parameter int N         = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_IN,
    output logic                 DATA_ENABLE,
    input  logic                 DATA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic                 DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 OVERFLOW
);
    localparam int CW = $clog2(N) + 1;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] STARTER_STATE = 2'd0;
    localparam logic [1:0] INPUT_STATE   = 2'd1;
    localparam logic [1:0] OUTPUT_STATE  = 2'd2;
    localparam logic [1:0] ENDER_STATE   = 2'd3;

    localparam logic [CW-1:0]        N_C = CW'(N);
    localparam logic [DATA_SIZE-1:0] N_D = DATA_SIZE'(N);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        index_q, index_d;
    logic [CW-1:0]        size_q, size_d;
    logic                 ready_q, ready_d;
    logic                 data_enable_q, data_enable_d;
    logic                 data_out_enable_q, data_out_enable_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;

    logic [DATA_SIZE-1:0] buffer_mem [0:N-1];
    logic                 buf_we;
    logic [AW-1:0]        buf_addr;
    logic [DATA_SIZE-1:0] buf_rdata;
    logic                 size_over;
    logic [CW-1:0]        size_clamped;
    logic                 last_index;

    assign buf_addr     = index_q[AW-1:0];
    assign buf_rdata    = buffer_mem[buf_addr];
    assign size_over    = (SIZE_IN > N_D);
    assign size_clamped = size_over ? N_C : SIZE_IN[CW-1:0];
    assign last_index   = (index_q == size_q - CW'(1));

    always_comb begin
        state_d           = state_q;
        index_d           = index_q;
        size_d            = size_q;
        ready_d           = 1'b0;
        data_enable_d     = 1'b0;
        data_out_enable_d = 1'b0;
        data_out_d        = data_out_q;
        overflow_d        = overflow_q;
        buf_we            = 1'b0;
        case (state_q)
            STARTER_STATE: begin
                if (START) begin
                    size_d     = size_clamped;
                    overflow_d = size_over;
                    index_d    = '0;
                    if (size_clamped == '0) begin
                        state_d = ENDER_STATE;
                    end else begin
                        data_enable_d = 1'b1;
                        state_d       = INPUT_STATE;
                    end
                end
            end
            INPUT_STATE: begin
                // The producer may answer any number of cycles after the request pulse.
                if (DATA_IN_ENABLE) begin
                    buf_we = 1'b1;
                    if (last_index) begin
                        index_d = '0;
                        state_d = OUTPUT_STATE;
                    end else begin
                        index_d       = index_q + CW'(1);
                        data_enable_d = 1'b1;
                    end
                end
            end
            OUTPUT_STATE: begin
                data_out_d        = buf_rdata;
                data_out_enable_d = 1'b1;
                if (last_index) begin
                    index_d = '0;
                    state_d = ENDER_STATE;
                end else begin
                    index_d = index_q + CW'(1);
                end
            end
            ENDER_STATE: begin
                ready_d = 1'b1;
                state_d = STARTER_STATE;
            end
            default: state_d = STARTER_STATE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q           <= STARTER_STATE;
            index_q           <= '0;
            size_q            <= '0;
            ready_q           <= 1'b0;
            data_enable_q     <= 1'b0;
            data_out_enable_q <= 1'b0;
            overflow_q        <= 1'b0;
            data_out_q        <= '0;
        end else begin
            state_q           <= state_d;
            index_q           <= index_d;
            size_q            <= size_d;
            ready_q           <= ready_d;
            data_enable_q     <= data_enable_d;
            data_out_enable_q <= data_out_enable_d;
            overflow_q        <= overflow_d;
            data_out_q        <= data_out_d;
        end
    end

    // Buffer contents survive reset; only the control state is cleared.
    always_ff @(posedge CLK) begin
        if (buf_we) begin
            buffer_mem[buf_addr] <= DATA_IN;
        end
    end

    assign READY           = ready_q;
    assign DATA_ENABLE     = data_enable_q;
    assign DATA_OUT_ENABLE = data_out_enable_q;
    assign DATA_OUT        = data_out_q;
    assign OVERFLOW        = overflow_q;
endmodule

// File: tb/tb_accelerator_convolutional_fnn_vector_receiver.sv
// Directed bench for the FNN vector receiver (N=8): load/replay, delays, overflow, reset, held START.
module tb_accelerator_convolutional_fnn_vector_receiver;
    localparam int DW = 64;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] size_in = '0;
    logic          die = 1'b0;
    logic [DW-1:0] din = '0;
    logic          ready, de, doe, ovf;
    logic [DW-1:0] dout;

    accelerator_convolutional_fnn_vector_receiver #(.DATA_SIZE(DW), .N(NB)) dut (
        .CLK(clk), .RST(rst), .START(start), .READY(ready), .SIZE_IN(size_in),
        .DATA_ENABLE(de), .DATA_IN_ENABLE(die), .DATA_IN(din),
        .DATA_OUT_ENABLE(doe), .DATA_OUT(dout), .OVERFLOW(ovf)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: observes outputs on the falling edge, tagged with the last rising-edge index.
    int            req_edge[$];
    int            rdy_edge[$];
    int            out_edge[$];
    logic [DW-1:0] out_q[$];
    always @(negedge clk) begin
        if (de)    req_edge.push_back(edge_cnt);
        if (ready) rdy_edge.push_back(edge_cnt);
        if (doe) begin
            out_q.push_back(dout);
            out_edge.push_back(edge_cnt);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int b_req, b_out, b_rdy, e0, r_edge;
    logic [DW-1:0] feed_val[16];
    int            feed_dly[16];
    bit ok;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_req = req_edge.size();
        b_out = out_q.size();
        b_rdy = rdy_edge.size();
    endtask

    task automatic begin_txn(input logic [DW-1:0] sz, input bit hold);
        size_in = sz;
        start   = 1'b1;
        e0      = edge_cnt + 1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_req(output bit found);
        int t;
        found = 1'b0;
        t = 0;
        while (t < 60 && !found) begin
            @(negedge clk);
            t++;
            if (de) found = 1'b1;
        end
    endtask

    task automatic feed(input int n);
        bit f;
        for (int k = 0; k < n; k++) begin
            wait_req(f);
            if (!f) begin
                check($sformatf("req_timeout%0d", k), 64'd0, 64'd1);
                return;
            end
            @(posedge clk);
            #1;
            repeat (feed_dly[k]) tick();
            die = 1'b1;
            din = feed_val[k];
            tick();
            die = 1'b0;
        end
    endtask

    task automatic wait_ready(input string tag, output int redge);
        int t;
        bit f;
        t = 0;
        f = 1'b0;
        redge = -1;
        while (t < 200 && !f) begin
            @(negedge clk);
            t++;
            if (ready) begin
                f = 1'b1;
                redge = edge_cnt;
            end
        end
        if (!f) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic verify(input string tag, input int nreq, input int nout, input int nrdy);
        logic [DW-1:0] got;
        check({tag, "_reqs"}, 64'(req_edge.size() - b_req), 64'(nreq));
        check({tag, "_outs"}, 64'(out_q.size() - b_out), 64'(nout));
        for (int k = 0; k < nout; k++) begin
            got = (b_out + k < out_q.size()) ? out_q[b_out + k] : 'x;
            check($sformatf("%s_out%0d", tag, k), got, feed_val[k]);
        end
        check({tag, "_ready_cnt"}, 64'(rdy_edge.size() - b_rdy), 64'(nrdy));
        if (nout > 1 && out_q.size() - b_out == nout)
            check({tag, "_no_gap"}, 64'(out_edge[b_out + nout - 1] - out_edge[b_out]), 64'(nout - 1));
        $display("txn %s: reqs=%0d outs=%0d ready=%0d overflow=%0b", tag,
                 req_edge.size() - b_req, out_q.size() - b_out, rdy_edge.size() - b_rdy, ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_de", 64'(de), 64'd0);
        check("rst_doe", 64'(doe), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // T1: size 4, producer answers one cycle after each request
        feed_val[0:3] = '{64'h11, 64'h22, 64'h33, 64'h44};
        feed_dly[0:3] = '{0, 0, 0, 0};
        mark();
        begin_txn(64'd4, 1'b0);
        feed(4);
        wait_ready("t1", r_edge);
        repeat (3) tick();
        verify("t1", 4, 4, 1);
        if (req_edge.size() >= b_req + 4) check("t1_req3_edge", 64'(req_edge[b_req + 3]), 64'(e0 + 6));
        if (out_q.size() >= b_out + 4) begin
            check("t1_first_out_edge", 64'(out_edge[b_out]), 64'(e0 + 9));
            check("t1_last_out_edge", 64'(out_edge[b_out + 3]), 64'(e0 + 12));
        end
        check("t1_ready_edge", 64'(r_edge), 64'(e0 + 13));
        check("t1_ovf", 64'(ovf), 64'd0);
        check("t1_dout_hold", dout, 64'h44);

        // T2: spurious strobe while idle, then size 3 with delays 0/5/2
        die = 1'b1;
        din = 64'hBAD;
        tick();
        die = 1'b0;
        tick();
        feed_val[0:2] = '{64'hA1, 64'hA2, 64'hA3};
        feed_dly[0:2] = '{0, 5, 2};
        mark();
        begin_txn(64'd3, 1'b0);
        feed(3);
        wait_ready("t2", r_edge);
        repeat (3) tick();
        verify("t2", 3, 3, 1);

        // T3: size 0 goes straight to READY
        mark();
        begin_txn(64'd0, 1'b0);
        wait_ready("t3", r_edge);
        repeat (3) tick();
        verify("t3", 0, 0, 1);
        check("t3_ready_edge", 64'(r_edge), 64'(e0 + 1));

        // T4: size 10 > N clamps to 8 and sets OVERFLOW
        for (int k = 0; k < 8; k++) begin
            feed_val[k] = 64'(k + 1) * 64'h0101;
            feed_dly[k] = 0;
        end
        mark();
        begin_txn(64'd10, 1'b0);
        check("t4_ovf_set", 64'(ovf), 64'd1);
        feed(8);
        wait_ready("t4", r_edge);
        repeat (3) tick();
        verify("t4", 8, 8, 1);
        if (out_q.size() >= b_out + 8) check("t4_first_out_edge", 64'(out_edge[b_out]), 64'(e0 + 17));
        check("t4_ovf_sticky", 64'(ovf), 64'd1);

        // T4b: next START with size 2 clears OVERFLOW
        feed_val[0:1] = '{64'h71, 64'h72};
        feed_dly[0:1] = '{0, 0};
        mark();
        begin_txn(64'd2, 1'b0);
        check("t4b_ovf_clear", 64'(ovf), 64'd0);
        feed(2);
        wait_ready("t4b", r_edge);
        repeat (3) tick();
        verify("t4b", 2, 2, 1);

        // T5: reset after 2 of 4 elements
        feed_val[0:1] = '{64'h51, 64'h52};
        begin_txn(64'd4, 1'b0);
        feed(2);
        check("t5_de_before_rst", 64'(de), 64'd1);
        check("t5_dout_before_rst", dout, 64'h72);
        rst = 1'b1;
        #1;
        check("t5_rst_de", 64'(de), 64'd0);
        check("t5_rst_dout", dout, 64'd0);
        check("t5_rst_doe", 64'(doe), 64'd0);
        check("t5_rst_ready", 64'(ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        feed_val[0:1] = '{64'h61, 64'h62};
        mark();
        begin_txn(64'd2, 1'b0);
        feed(2);
        wait_ready("t5", r_edge);
        repeat (3) tick();
        verify("t5", 2, 2, 1);

        // T6: START held high across two transactions
        feed_val[0:1] = '{64'h81, 64'h82};
        mark();
        begin_txn(64'd2, 1'b1);
        feed(2);
        wait_ready("t6a", r_edge);
        feed(2);
        wait_ready("t6b", e0);
        start = 1'b0;
        repeat (6) tick();
        check("t6_reqs", 64'(req_edge.size() - b_req), 64'd4);
        check("t6_outs", 64'(out_q.size() - b_out), 64'd4);
        check("t6_ready_cnt", 64'(rdy_edge.size() - b_rdy), 64'd2);
        if (req_edge.size() >= b_req + 3) check("t6_restart_edge", 64'(req_edge[b_req + 2]), 64'(r_edge + 1));
        if (out_q.size() >= b_out + 4) check("t6_out3", out_q[b_out + 3], 64'h82);
        $display("txn t6: reqs=%0d outs=%0d ready=%0d", req_edge.size() - b_req,
                 out_q.size() - b_out, rdy_edge.size() - b_rdy);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
